pid_integrator: RTL and testbench

Parametrised integral-term accumulator for the line-follower PID controller. It sits between the error saturation stage and the PID summer. It integrates the signed saturated error on each valid sample, with optional decimation. It clamps or holds on overflow. After the line is reacquired it ignores a programmable number of samples before integrating again. A small state machine controls clearing, freezing and integrating, based on go, moving and line_present.

---
 rtl/pid_integrator.sv | 131 +++++++++++++
 tb/tb_pid_integrator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_integrator.sv
// Integral-term accumulator for the line-follower PID loop: integrates the saturated
// error while running, with decimation, post-acquisition holdoff and overflow clamp/hold.
module pid_integrator #(
    parameter int ERR_W    = 11,
    parameter int ACC_W    = 16,
    parameter int OUT_W    = 10,
    parameter int DECIM    = 1,
    parameter int HOLDOFF  = 4,
    parameter bit SAT_MODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] err_sat,
    input  logic                    err_vld,
    input  logic                    go,
    input  logic                    moving,
    input  logic                    line_present,
    output logic signed [OUT_W-1:0] I_term,
    output logic                    sat_flag,
    output logic                    int_active
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOST = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]              HOLD_LAST  = 8'(HOLDOFF);
    localparam logic [7:0]              DECIM_LAST = 8'(DECIM - 1);

    state_t                  state_reg, state_next;
    logic                    line_q_reg;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic                    sat_reg;
    logic [7:0]              hold_cnt_reg, hold_cnt_next;
    logic [7:0]              decim_cnt_reg, decim_cnt_next;

    logic                    rise;
    logic [ACC_W:0]          sum;
    logic                    pos_ovf, neg_ovf;
    logic signed [ACC_W-1:0] acc_int;

    assign rise = line_present & ~line_q_reg;

    // One guard bit above the accumulator: the top two bits disagreeing means overflow.
    always_comb begin
        sum     = {{(ACC_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat} + {acc_reg[ACC_W-1], acc_reg};
        pos_ovf = (sum[ACC_W:ACC_W-1] == 2'b01);
        neg_ovf = (sum[ACC_W:ACC_W-1] == 2'b10);
        acc_int = sum[ACC_W-1:0];
        if (pos_ovf) begin
            acc_int = SAT_MODE ? ACC_MAX : acc_reg;
        end else if (neg_ovf) begin
            acc_int = SAT_MODE ? ACC_MIN : acc_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            line_q_reg    <= 1'b0;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            hold_cnt_reg  <= '0;
            decim_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            line_q_reg    <= line_present;
            acc_reg       <= acc_next;
            sat_reg       <= (acc_next == ACC_MAX) || (acc_next == ACC_MIN);
            hold_cnt_reg  <= hold_cnt_next;
            decim_cnt_reg <= decim_cnt_next;
        end
    end

    // Rules are ordered by priority; the first matching branch wins.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        hold_cnt_next  = hold_cnt_reg;
        decim_cnt_next = decim_cnt_reg;
        if (!go || !moving) begin
            state_next = S_IDLE;
            acc_next   = '0;
        end else if (state_reg == S_IDLE) begin
            if (line_present) begin
                state_next    = S_HOLD;
                acc_next      = '0;
                hold_cnt_next = '0;
            end else begin
                state_next = S_LOST;
            end
        end else if (rise) begin
            state_next     = S_HOLD;
            acc_next       = '0;
            hold_cnt_next  = '0;
            decim_cnt_next = '0;
        end else if (!line_present && (state_reg == S_HOLD || state_reg == S_RUN)) begin
            state_next = S_LOST;
        end else if (state_reg == S_HOLD) begin
            if (HOLD_LAST == 8'd0) begin
                state_next = S_RUN;
            end else if (err_vld) begin
                if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
                if (hold_cnt_reg + 8'd1 == HOLD_LAST) begin
                    state_next = S_RUN;
                end
            end
        end else if (state_reg == S_RUN && err_vld) begin
            if (decim_cnt_reg == DECIM_LAST) begin
                acc_next       = acc_int;
                decim_cnt_next = '0;
            end else begin
                decim_cnt_next = decim_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        int_active = (state_reg == S_RUN);
        I_term     = acc_reg[ACC_W-1 -: OUT_W];
        sat_flag   = sat_reg;
    end

endmodule

// File: tb/tb_pid_integrator.sv
// Scoreboard bench for pid_integrator: three parameterisations share one stimulus stream,
// expected results are queued by the driver and checked by independent monitors.
module tb_pid_integrator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [10:0] err_sat;
    logic               err_vld;
    logic               go;
    logic               moving;
    logic               line_present;

    logic signed [9:0]  it_a, it_b, it_c;
    logic               sat_a, sat_b, sat_c;
    logic               act_a, act_b, act_c;

    always #5 clk = ~clk;

    pid_integrator #(.ERR_W(11), .ACC_W(16), .OUT_W(10), .DECIM(1), .HOLDOFF(4), .SAT_MODE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .err_sat(err_sat), .err_vld(err_vld), .go(go), .moving(moving),
        .line_present(line_present), .I_term(it_a), .sat_flag(sat_a), .int_active(act_a)
    );
    pid_integrator #(.ERR_W(11), .ACC_W(16), .OUT_W(10), .DECIM(1), .HOLDOFF(4), .SAT_MODE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .err_sat(err_sat), .err_vld(err_vld), .go(go), .moving(moving),
        .line_present(line_present), .I_term(it_b), .sat_flag(sat_b), .int_active(act_b)
    );
    pid_integrator #(.ERR_W(11), .ACC_W(16), .OUT_W(10), .DECIM(3), .HOLDOFF(0), .SAT_MODE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .err_sat(err_sat), .err_vld(err_vld), .go(go), .moving(moving),
        .line_present(line_present), .I_term(it_c), .sat_flag(sat_c), .int_active(act_c)
    );

    typedef struct {
        int                 id;
        logic signed [15:0] acc;
        logic               act;
        string              name;
    } exp_t;

    exp_t sb_q[$];
    int   chk_n   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    event async_chk;

    function automatic void push(input int id, input int a, input logic act, input string name);
        exp_t e;
        e.id   = id;
        e.acc  = 16'(a);
        e.act  = act;
        e.name = name;
        sb_q.push_back(e);
    endfunction

    function automatic void expect_at(input int id, input int a, input logic act, input string name);
        push(id, a, act, name);
        chk_n++;
    endfunction

    task automatic cyc(input logic v, input int e, input logic g, input logic m, input logic l);
        @(negedge clk);
        err_vld      = v;
        err_sat      = 11'(e);
        go           = g;
        moving       = m;
        line_present = l;
        chk_n        = 0;
    endtask

    task automatic check_one();
        exp_t               e;
        logic signed [15:0] a_acc;
        logic signed [9:0]  a_it, e_it;
        logic               a_sat, a_act, e_sat;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL empty_queue: monitor expected an entry, got none");
            return;
        end
        e = sb_q.pop_front();
        case (e.id)
            0:       begin a_acc = dut_a.acc_reg; a_it = it_a; a_sat = sat_a; a_act = act_a; end
            1:       begin a_acc = dut_b.acc_reg; a_it = it_b; a_sat = sat_b; a_act = act_b; end
            default: begin a_acc = dut_c.acc_reg; a_it = it_c; a_sat = sat_c; a_act = act_c; end
        endcase
        e_it  = e.acc[15:6];
        e_sat = (e.acc == 16'sh7FFF) || (e.acc == 16'sh8000);
        n_tests++;
        if (a_acc !== e.acc || a_it !== e_it || a_sat !== e_sat || a_act !== e.act) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d: got acc=%h I_term=%0d sat=%b act=%b, expected acc=%h I_term=%0d sat=%b act=%b",
                     e.name, e.id, a_acc, a_it, a_sat, a_act, e.acc, e_it, e_sat, e.act);
        end else begin
            $display("[TB] ok   %s dut%0d: acc=%h I_term=%0d sat=%b act=%b", e.name, e.id, a_acc, a_it, a_sat, a_act);
        end
    endtask

    // Clocked monitor: entries queued in a cycle are checked just after the following edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            repeat (chk_n) check_one();
        end
    end

    // Asynchronous monitor: checks everything queued the moment it is triggered.
    initial begin
        forever begin
            @(async_chk);
            while (sb_q.size() > 0) check_one();
        end
    end

    initial begin
        rst = 1'b1; go = 1'b0; moving = 1'b0; line_present = 1'b0; err_vld = 1'b0; err_sat = '0;
        #3;
        push(0, 0, 1'b0, "reset"); push(1, 0, 1'b0, "reset"); push(2, 0, 1'b0, "reset");
        -> async_chk;
        @(negedge clk);
        rst = 1'b0;

        // Acquisition, holdoff of 4 strobes, then integration of +64
        cyc(0, 0, 1, 1, 1);   expect_at(0, 0, 1'b0, "acquire"); expect_at(1, 0, 1'b0, "acquire");
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 64, 1, 1, 1);
            if (k == 3) expect_at(0, 0, 1'b0, "holdoff3");
            if (k == 4) begin expect_at(0, 0, 1'b1, "holdoff4"); expect_at(1, 0, 1'b1, "holdoff4"); end
        end
        cyc(1, 64, 1, 1, 1);  expect_at(0, 64, 1'b1, "run1");
        cyc(1, 64, 1, 1, 1);  expect_at(0, 128, 1'b1, "run2"); expect_at(1, 128, 1'b1, "run2");

        // Saturation: clamp (dut_a) versus hold (dut_b)
        cyc(0, 0, 0, 1, 1);   expect_at(0, 0, 1'b0, "go_drop"); expect_at(2, 0, 1'b0, "go_drop");
        cyc(0, 0, 1, 1, 1);
        for (int k = 1; k <= 4; k++) cyc(1, 0, 1, 1, 1);
        expect_at(0, 0, 1'b1, "sat_start"); expect_at(1, 0, 1'b1, "sat_start");
        for (int k = 1; k <= 40; k++) begin
            cyc(1, 1023, 1, 1, 1);
            if (k == 32) begin expect_at(0, 'h7FE0, 1'b1, "sat32"); expect_at(1, 'h7FE0, 1'b1, "sat32"); end
            if (k == 33) begin expect_at(0, 'h7FFF, 1'b1, "sat33"); expect_at(1, 'h7FE0, 1'b1, "sat33"); end
            if (k == 40) begin expect_at(0, 'h7FFF, 1'b1, "sat40"); expect_at(1, 'h7FE0, 1'b1, "sat40"); end
        end

        // Line loss freezes, reacquire clears; decimation by 3 on dut_c
        cyc(0, 0, 1, 1, 0);   expect_at(0, 'h7FFF, 1'b0, "lost"); expect_at(1, 'h7FE0, 1'b0, "lost");
        cyc(0, 0, 1, 1, 1);   expect_at(0, 0, 1'b0, "reacquire"); expect_at(2, 0, 1'b0, "reacquire");
        cyc(0, 0, 1, 1, 1);   expect_at(2, 0, 1'b1, "c_run"); expect_at(0, 0, 1'b0, "a_hold");
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 10, 1, 1, 1);
            expect_at(2, 10 * (k / 3), 1'b1, "decim");
            if (k == 4) expect_at(0, 0, 1'b1, "a_holdoff_done");
            if (k == 9) expect_at(0, 50, 1'b1, "a_after_decim");
        end

        // acc = 500, lose line with strobes, reacquire with a simultaneous strobe
        cyc(1, 450, 1, 1, 1); expect_at(0, 500, 1'b1, "acc500");
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 64, 1, 1, 0);
            if (k == 1 || k == 5) expect_at(0, 500, 1'b0, "lost_strobe");
        end
        cyc(1, 64, 1, 1, 1);  expect_at(0, 0, 1'b0, "rise_discard");
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 64, 1, 1, 1);
            if (k == 3) expect_at(0, 0, 1'b0, "reholdoff3");
            if (k == 4) expect_at(0, 0, 1'b1, "reholdoff4");
        end
        cyc(1, 64, 1, 1, 1);  expect_at(0, 64, 1'b1, "reintegrate");

        // Priority: moving drops together with a rise and a strobe
        cyc(1, -364, 1, 1, 1); expect_at(0, -300, 1'b1, "neg300");
        cyc(0, 0, 1, 1, 0);    expect_at(0, -300, 1'b0, "lost_neg");
        cyc(1, 100, 1, 0, 1);  expect_at(0, 0, 1'b0, "prio_idle");

        // Build acc = 0x4000, then assert reset between clock edges
        cyc(0, 0, 1, 1, 1);
        for (int k = 1; k <= 4; k++)  cyc(1, 0, 1, 1, 1);
        for (int k = 1; k <= 16; k++) cyc(1, 1023, 1, 1, 1);
        cyc(1, 16, 1, 1, 1);  expect_at(0, 'h4000, 1'b1, "acc4000");
        @(negedge clk);
        chk_n   = 0;
        err_vld = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        push(0, 0, 1'b0, "async_rst"); push(1, 0, 1'b0, "async_rst"); push(2, 0, 1'b0, "async_rst");
        -> async_chk;
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 1, 1);   expect_at(0, 0, 1'b0, "post_rst");
        cyc(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL leftover: %0d entries unchecked, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
